// File: rtl/mycpu_pkg.sv
// Shared CPU-wide widths and constants, plus small fetch-path helpers.
package mycpu_pkg;

    localparam int unsigned BR_BUS_WD        = 33;
    localparam int unsigned FS_TO_DS_BUS_WD  = 64;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } br_bus_t;

    function automatic logic pc_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Port bundle for the one-entry instruction stall buffer used by the fetch stage.
interface if_stage_if;

    logic        capture;
    logic        clear;
    logic [31:0] din;
    logic        valid;
    logic [31:0] dout;

    modport master (output capture, output clear, output din, input valid, input dout);
    modport slave  (input capture, input clear, input din, output valid, output dout);

endinterface

// File: rtl/if_inst_buf.sv
// One-entry holding register for the SRAM word of an instruction stalled in IF.
module if_inst_buf (
    input  logic       clk,
    input  logic       resetn,
    if_stage_if.slave  buf_io
);

    logic        valid_q, valid_d;
    logic [31:0] data_q, data_d;

    // A clear always wins so a redirect never leaves a stale word behind.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (buf_io.clear) begin
            valid_d = 1'b0;
        end else if (buf_io.capture) begin
            valid_d = 1'b1;
            data_d  = buf_io.din;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            data_q  <= 32'h0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign buf_io.valid = valid_q;
    assign buf_io.dout  = data_q;

endmodule

// File: rtl/if_stage.sv
// Fetch stage: drives the instruction SRAM and hands {inst, pc} to decode.
// Define IF_ADEF_EN to suppress misaligned fetches and flag them with fs_excp_adef.
module if_stage
    import mycpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ds_allowin,
    input  logic [BR_BUS_WD-1:0]       br_bus,
    output logic                       inst_sram_en,
    output logic [3:0]                 inst_sram_we,
    output logic [31:0]                inst_sram_addr,
    output logic [31:0]                inst_sram_wdata,
    input  logic [31:0]                inst_sram_rdata,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic                       fs_excp_adef
);

    br_bus_t     br;
    logic        to_fs_valid_q, to_fs_valid_d;
    logic        fs_valid_q, fs_valid_d;
    logic [31:0] fs_pc_q, fs_pc_d;
    logic        adef_q, adef_d;
    logic [31:0] nextpc;
    logic [31:0] fs_inst;
    logic        fs_allowin;
    logic        fs_advance;
    logic        fetch_adef;

    if_stage_if buf_io ();

    if_inst_buf u_inst_buf (
        .clk    (clk),
        .resetn (resetn),
        .buf_io (buf_io)
    );

    assign br = br_bus_t'(br_bus);

    always_comb begin
        nextpc = br.taken ? br.target : fs_pc_q + 32'd4;
`ifdef IF_ADEF_EN
        fetch_adef = pc_misaligned(nextpc);
`else
        fetch_adef = 1'b0;
`endif
        fs_allowin     = !fs_valid_q || ds_allowin || br.taken;
        fs_advance     = to_fs_valid_q && fs_allowin;
        fs_to_ds_valid = fs_valid_q && !br.taken;

        to_fs_valid_d = 1'b1;
        fs_valid_d    = fs_valid_q;
        fs_pc_d       = fs_pc_q;
        adef_d        = adef_q;
        // A misaligned fetch still advances the stage; it just never reaches the SRAM.
        if (fs_advance) begin
            fs_valid_d = 1'b1;
            fs_pc_d    = nextpc;
            adef_d     = fetch_adef;
        end

        // The SRAM word is only valid for one cycle, so hold it on the first stall cycle.
        buf_io.capture = fs_valid_q && !ds_allowin && !br.taken && !buf_io.valid;
        buf_io.clear   = (fs_to_ds_valid && ds_allowin) || br.taken;
        buf_io.din     = inst_sram_rdata;

        fs_inst = inst_sram_rdata;
        if (adef_q) begin
            fs_inst = 32'h0;
        end else if (buf_io.valid) begin
            fs_inst = buf_io.dout;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            to_fs_valid_q <= 1'b0;
            fs_valid_q    <= 1'b0;
            fs_pc_q       <= RESET_PC - 32'd4;
            adef_q        <= 1'b0;
        end else begin
            to_fs_valid_q <= to_fs_valid_d;
            fs_valid_q    <= fs_valid_d;
            fs_pc_q       <= fs_pc_d;
            adef_q        <= adef_d;
        end
    end

    assign inst_sram_en    = fs_advance && !fetch_adef;
    assign inst_sram_we    = 4'b0000;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_wdata = 32'h0;
    assign fs_to_ds_bus    = {fs_inst, fs_pc_q};
    assign fs_excp_adef    = adef_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized traffic vs a fetch model.
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h1c00_0000;
`ifdef IF_ADEF_EN
    localparam bit ADEF_EN = 1'b1;
`else
    localparam bit ADEF_EN = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic        ds_allowin;
    logic [32:0] br_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
    logic        fs_excp_adef;

    int checks = 0;
    int errors = 0;

    logic [31:0] dut_deliv[$];

    // Model of what the fetch stage must hold: no buffer, the instruction is simply mem[pc].
    logic        m_go, m_valid, m_adef;
    logic [31:0] m_pc;

    logic        r_ds, r_br;
    logic [31:0] r_tgt;

    logic [31:0] exp_list [8] = '{32'h1c000000, 32'h1c000004, 32'h1c000040, 32'h1c000080,
                                  32'hfffffff8, 32'hfffffffc, 32'h00000000, 32'h1c000200};

    if_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .ds_allowin      (ds_allowin),
        .br_bus          (br_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .fs_to_ds_valid  (fs_to_ds_valid),
        .fs_to_ds_bus    (fs_to_ds_bus),
        .fs_excp_adef    (fs_excp_adef)
    );

    if_stage_if ub_io ();

    if_inst_buf u_ub (
        .clk    (clk),
        .resetn (resetn),
        .buf_io (ub_io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9e3779b1) ^ 32'h0f0f_5a5a;
    endfunction

    // Synchronous SRAM: data for a request appears the next cycle, garbage otherwise.
    always @(posedge clk) begin
        inst_sram_rdata <= inst_sram_en ? word_at(inst_sram_addr) : $urandom();
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endfunction

    task automatic model_cycle();
        logic [31:0] nxt;
        logic        taken, move, bad, exp_en;
        if (!resetn) begin
            chk("rst_en", 64'(inst_sram_en), 64'd0);
            chk("rst_valid", 64'(fs_to_ds_valid), 64'd0);
            chk("rst_adef", 64'(fs_excp_adef), 64'd0);
            chk("rst_pc", 64'(fs_to_ds_bus[31:0]), 64'(RST_PC - 32'd4));
            m_go    = 1'b0;
            m_valid = 1'b0;
            m_adef  = 1'b0;
            m_pc    = RST_PC - 32'd4;
            return;
        end
        taken  = br_bus[32];
        nxt    = taken ? br_bus[31:0] : m_pc + 32'd4;
        move   = m_go && (!m_valid || ds_allowin || taken);
        bad    = ADEF_EN && (nxt[1:0] != 2'b00);
        exp_en = move && !bad;
        chk("en", 64'(inst_sram_en), 64'(exp_en));
        if (exp_en) chk("addr", 64'(inst_sram_addr), 64'(nxt));
        chk("we_wdata", 64'({inst_sram_we, inst_sram_wdata}), 64'd0);
        chk("fs_valid", 64'(fs_to_ds_valid), 64'(m_valid && !taken));
        chk("adef", 64'(fs_excp_adef), 64'(m_adef));
        if (m_valid) begin
            chk("pc", 64'(fs_to_ds_bus[31:0]), 64'(m_pc));
            chk("inst", 64'(fs_to_ds_bus[63:32]), 64'(m_adef ? 32'h0 : word_at(m_pc)));
        end
        if (fs_to_ds_valid && ds_allowin) dut_deliv.push_back(fs_to_ds_bus[31:0]);
        if (move) begin
            m_valid = 1'b1;
            m_pc    = nxt;
            m_adef  = bad;
        end
        m_go = 1'b1;
    endtask

    always @(negedge clk) begin
        #1;
        model_cycle();
    end

    task automatic cyc(input logic ds, input logic br, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        ds_allowin = ds;
        br_bus     = {br, tgt};
        @(negedge clk);
        #2;
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: bench did not finish, checks %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        resetn        = 1'b0;
        ds_allowin    = 1'b1;
        br_bus        = '0;
        ub_io.capture = 1'b0;
        ub_io.clear   = 1'b0;
        ub_io.din     = 32'h0;
        m_go = 1'b0; m_valid = 1'b0; m_adef = 1'b0; m_pc = RST_PC - 32'd4;

        #12;
        chk("lit_rst_en", 64'(inst_sram_en), 64'd0);
        chk("lit_rst_pc", 64'(fs_to_ds_bus[31:0]), 64'h1bfffffc);
        #8;
        resetn = 1'b1;

        cyc(1'b1, 1'b0, 32'h0);
        chk("lit_first_en", 64'(inst_sram_en), 64'd1);
        chk("lit_first_addr", 64'(inst_sram_addr), 64'h1c000000);
        cyc(1'b1, 1'b0, 32'h0);
        chk("lit_first_pc", 64'(fs_to_ds_bus[31:0]), 64'h1c000000);
        chk("lit_first_valid", 64'(fs_to_ds_valid), 64'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 32'h0);
            chk("lit_stall_en", 64'(inst_sram_en), 64'd0);
            chk("lit_stall_pc", 64'(fs_to_ds_bus[31:0]), 64'h1c000004);
            chk("lit_stall_inst", 64'(fs_to_ds_bus[63:32]), 64'(word_at(32'h1c000004)));
        end
        cyc(1'b1, 1'b0, 32'h0);
        chk("lit_release_addr", 64'(inst_sram_addr), 64'h1c000008);
        cyc(1'b1, 1'b1, 32'h1c000040);
        chk("lit_br_valid", 64'(fs_to_ds_valid), 64'd0);
        chk("lit_br_addr", 64'(inst_sram_addr), 64'h1c000040);
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 32'h1c000080);
        chk("lit_brstall_en", 64'(inst_sram_en), 64'd1);
        chk("lit_brstall_addr", 64'(inst_sram_addr), 64'h1c000080);
        cyc(1'b1, 1'b0, 32'h0);
        chk("lit_brstall_pc", 64'(fs_to_ds_bus[31:0]), 64'h1c000080);
        cyc(1'b1, 1'b1, 32'hfffffff8);
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        chk("lit_wrap_addr", 64'(inst_sram_addr), 64'h00000000);
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 32'h1c000100);
        cyc(1'b1, 1'b1, 32'h1c000200);
        chk("lit_br2_valid", 64'(fs_to_ds_valid), 64'd0);
        chk("lit_br2_addr", 64'(inst_sram_addr), 64'h1c000200);
        cyc(1'b1, 1'b0, 32'h0);

        chk("deliv_cnt", 64'(dut_deliv.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < dut_deliv.size()) chk("deliv_pc", 64'(dut_deliv[i]), 64'(exp_list[i]));
        end

`ifdef IF_ADEF_EN
        cyc(1'b1, 1'b1, 32'h1c000042);
        chk("lit_adef_en", 64'(inst_sram_en), 64'd0);
        cyc(1'b1, 1'b0, 32'h0);
        chk("lit_adef_pc", 64'(fs_to_ds_bus[31:0]), 64'h1c000042);
        chk("lit_adef_inst", 64'(fs_to_ds_bus[63:32]), 64'd0);
        chk("lit_adef_flag", 64'(fs_excp_adef), 64'd1);
        cyc(1'b1, 1'b1, 32'h1c000000);
        cyc(1'b1, 1'b0, 32'h0);
`endif

        // Stall buffer on its own: capture, then clear beating a simultaneous capture.
        @(posedge clk); #1;
        ub_io.capture = 1'b1;
        ub_io.din     = 32'hcafe_f00d;
        @(posedge clk); #1;
        chk("buf_valid", 64'(ub_io.valid), 64'd1);
        chk("buf_data", 64'(ub_io.dout), 64'hcafef00d);
        ub_io.clear = 1'b1;
        ub_io.din   = 32'h1234_5678;
        @(posedge clk); #1;
        chk("buf_clear", 64'(ub_io.valid), 64'd0);
        ub_io.capture = 1'b0;
        ub_io.clear   = 1'b0;

        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) begin
                @(posedge clk); #1;
                br_bus = '0;
                #2;
                resetn = 1'b0;
                repeat (2) @(negedge clk);
                resetn = 1'b1;
            end
            r_ds  = ($urandom_range(0, 99) < 70);
            r_br  = ($urandom_range(0, 99) < 15);
            r_tgt = $urandom();
            if (!(ADEF_EN && ($urandom_range(0, 3) == 0))) r_tgt[1:0] = 2'b00;
            cyc(r_ds, r_br, r_tgt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
